// File: rtl/fp_normalize_round.sv
// Post-add normalization and round-to-nearest-even stage of the FP adder.
// Takes the signed mantissa sum and the common exponent. Normalizes one bit
// per cycle, rounds once, then holds the result until downstream accepts it.
module fp_normalize_round #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int EXPONENT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MANTISSA_WIDTH+5:0]   sum,
  input  logic [EXPONENT_WIDTH-1:0]   exp_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sign_out,
  output logic [EXPONENT_WIDTH-1:0]   exp_out,
  output logic [MANTISSA_WIDTH-1:0]   man_out,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        zero
);

  localparam int MW   = MANTISSA_WIDTH;
  localparam int EW   = EXPONENT_WIDTH;
  localparam int SW   = MW + 6;   // signed sum width
  localparam int MAGW = MW + 5;   // magnitude: carry, hidden, fraction, G, R, S
  localparam int XW   = EW + 2;   // internal exponent width

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q,  sign_d;
  logic [MAGW-1:0]   mag_q,   mag_d;
  logic [XW-1:0]     exp_q,   exp_d;
  logic              osign_q, osign_d;
  logic [EW-1:0]     oexp_q,  oexp_d;
  logic [MW-1:0]     oman_q,  oman_d;
  logic              ovf_q,   ovf_d;
  logic              unf_q,   unf_d;
  logic              zero_q,  zero_d;

  logic [SW-1:0]     sum_neg;
  logic [MAGW-1:0]   mag_in;
  logic              round_up;
  logic [MW+1:0]     rsum;
  logic [XW-1:0]     exp_rnd;
  logic [XW-1:0]     exp_max;

  assign sum_neg = -sum;
  assign mag_in  = sum[SW-1] ? sum_neg[MAGW-1:0] : sum[MAGW-1:0];

  // Nearest-even: round up above half, or at exactly half when the LSB is odd.
  assign round_up = mag_q[2] & (mag_q[1] | mag_q[0] | mag_q[3]);
  assign rsum     = {1'b0, mag_q[MAGW-2:3]} + {{(MW+1){1'b0}}, round_up};
  assign exp_rnd  = exp_q + {{(XW-1){1'b0}}, rsum[MW+1]};
  assign exp_max  = {2'b00, {EW{1'b1}}};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sign_out  = osign_q;
  assign exp_out   = oexp_q;
  assign man_out   = oman_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign zero      = zero_q;

  // State and datapath registers; async reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      osign_q <= 1'b0;
      oexp_q  <= '0;
      oman_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      osign_q <= osign_d;
      oexp_q  <= oexp_d;
      oman_q  <= oman_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state and datapath: capture, one normalize action per cycle, round, hold.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    osign_d = osign_q;
    oexp_d  = oexp_q;
    oman_d  = oman_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = sum[SW-1];
          mag_d   = mag_in;
          exp_d   = {2'b00, exp_in};
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          osign_d = 1'b0;
          oexp_d  = '0;
          oman_d  = '0;
          state_d = S_DONE;
        end else if (mag_q[MAGW-1]) begin
          // Carry: drop one bit, folding it into sticky so rounding stays exact.
          mag_d   = {1'b0, mag_q[MAGW-1:2], mag_q[1] | mag_q[0]};
          exp_d   = exp_q + {{(XW-1){1'b0}}, 1'b1};
          state_d = S_ROUND;
        end else if (mag_q[MAGW-2]) begin
          state_d = S_ROUND;
        end else if (exp_q == {{(XW-1){1'b0}}, 1'b1}) begin
          unf_d   = 1'b1;
          osign_d = sign_q;
          oexp_d  = '0;
          oman_d  = '0;
          state_d = S_DONE;
        end else begin
          mag_d   = {mag_q[MAGW-2:0], 1'b0};
          exp_d   = exp_q - {{(XW-1){1'b0}}, 1'b1};
        end
      end
      S_ROUND: begin
        osign_d = sign_q;
        if (exp_rnd >= exp_max) begin
          ovf_d  = 1'b1;
          oexp_d = '1;
          oman_d = '0;
        end else begin
          // On a rounding carry rsum is exactly 2^(MW+1), so its low bits are already 0.
          oexp_d = exp_rnd[EW-1:0];
          oman_d = rsum[MW-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
Post-addition stage of the floating-point adder/subtractor. It takes the signed mantissa sum from the mantissa add/sub stage and the common (larger) exponent, then produces a normalized, IEEE 754 round-to-nearest-even result: sign, biased exponent and fraction. Normalization is iterative, one bit per cycle, with a valid/ready handshake on both sides.

Parameters:
MANTISSA_WIDTH, 23, stored fraction width.
EXPONENT_WIDTH, 8, biased exponent width.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  sum/exp_in valid.
in_ready  output  1  stage can accept (high only in IDLE).
sum  input  MANTISSA_WIDTH+6  two's-complement mantissa sum; upstream sign-extends {carry_out, result}.
exp_in  input  EXPONENT_WIDTH  common biased exponent, range 1..2^EW-2.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
sign_out  output  1  result sign.
exp_out  output  EXPONENT_WIDTH  biased exponent.
man_out  output  MANTISSA_WIDTH  fraction, hidden bit dropped.
overflow  output  1  result rounded to infinity.
underflow  output  1  result flushed to zero due to exponent underflow.
zero  output  1  exact zero result (sum == 0).

Behaviour:
- Magnitude layout, MW = MANTISSA_WIDTH, mag = |sum|, MW+5 bits:
  - [MW+4] carry (value 2.x).
  - [MW+3] hidden bit.
  - [MW+2:3] fraction.
  - [2] G, [1] R, [0] S.
- Exponent arithmetic uses EW+2 bits internally. No NaN/inf inputs; specials are handled upstream.
- Reset: state IDLE. out_valid, sign_out, exp_out, man_out, overflow, underflow and zero are all 0. in_ready = 1. Reset mid-operation drops the transaction without output.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture sign = sum MSB, mag = |sum|, exp = exp_in. Go to NORM.
- NORM (one action per cycle):
  - mag == 0: zero = 1, sign/exp/man = 0. Go to DONE.
  - mag[MW+4] = 1: shift right 1, OR the dropped bit into S, exp + 1. Go to ROUND.
  - mag[MW+3] = 1: go to ROUND.
  - Otherwise, if exp == 1: underflow = 1, output +/-0 (sign kept, exp = 0, man = 0). Go to DONE.
  - Otherwise: shift left 1 with 0 in, exp - 1. Stay in NORM.
- ROUND (one cycle):
  - round_up = G & (R | S | mag[3]).
  - Add round_up to mag[MW+3:3]. If this carries out, exp + 1 and the fraction becomes 0.
  - If final exp >= 2^EW-1: overflow = 1, exp_out = all ones, man_out = 0 (infinity, sign kept).
  - Go to DONE.
- DONE:
  - out_valid = 1. Outputs and flags are held stable while out_ready = 0.
  - On out_ready: out_valid drops next cycle, flags clear, return to IDLE.
- in_ready = 0 in NORM, ROUND and DONE. No new input is accepted in the cycle out_valid drops.
- Latency is counted from the accepting edge to the first cycle out_valid = 1:
  - 3 cycles for normalized or carry inputs.
  - 3 + k cycles with k left shifts.
  - 2 cycles for zero.
  - 2 + k cycles for underflow flush.
- Flags are mutually exclusive. At most one of overflow, underflow, zero is set per result.

Test Plan:
1. 1.0+1.0: sum = 0x08000000, exp_in = 127 -> sign 0, exp 128, man 0, out_valid 3 cycles after accept.
2. Negative: sum = 0x1C000000 (-0x04000000, 29 bits), exp_in = 127 -> sign 1, exp 127, man 0, no flags.
3. Cancellation: sum = 0x00000008, exp_in = 100 -> 23 left shifts, exp 77, man 0, out_valid at cycle 26; in_ready low throughout.
4. Round to nearest even:
   - sum = 0x04000004 (tie, lsb 0) -> man 0.
   - sum = 0x0400000C (tie, lsb 1) -> man 2.
   - sum = 0x04000006 -> man 1.
5. Rounding carry and overflow:
   - sum = 0x07FFFFFC, exp_in = 200 -> exp 201, man 0.
   - Same sum, exp_in = 254 -> overflow = 1, exp 0xFF, man 0.
6. Edge cases:
   - sum = 0 -> zero = 1 after 2 cycles.
   - sum = 0x02000000, exp_in = 1 -> underflow = 1, exp 0, man 0.
   - Hold out_ready = 0 for 5 cycles -> outputs stable, in_ready = 0.
   - Assert rst during NORM -> IDLE, out_valid 0, in_ready 1 immediately.
